// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: REQ -> WAIT -> HOLD with redirect
// support and a one-deep discard flag for stale memory responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      imem,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready,
  output logic              misaligned
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        mis_q, mis_d;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    mis_d     = 1'b0;

    if (reset) begin
      state_d = S_REQ;
      pc_d    = RESET_PC;
      valid_d = 1'b0;
      instr_d = NOP;
      ipc_d   = 32'h0;
      // A request in flight keeps owing us a response after reset.
      discard_d = 1'b0;
      if (((state_q == S_WAIT) ||
           (state_q == S_REQ && discard_q)) &&
          !imem.imem_rvalid)
        discard_d = 1'b1;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem.imem_gnt) begin
            state_d = S_WAIT;
            if (redirect) discard_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (discard_q || redirect) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              instr_d = imem.imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              state_d = S_HOLD;
            end
          end else if (redirect) begin
            discard_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end else if (instr_ready) begin
            valid_d = 1'b0;
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase

      if (redirect) begin
        pc_d  = {redirect_pc[31:2], 2'b00};
        mis_d = |redirect_pc[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    discard_q <= discard_d;
    pc_q      <= pc_d;
    valid_q   <= valid_d;
    instr_q   <= instr_d;
    ipc_q     <= ipc_d;
    mis_q     <= mis_d;
  end

  assign imem.imem_req  = (state_q == S_REQ) && !reset;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign misaligned     = mis_q;

endmodule
